// File: rtl/mux_rr_arbiter_pkg.sv
// Shared types and helpers for the 4-requester round-robin mux arbiter.
// Optional lock feature is compiled in with MUX_ARB_LOCK_EN.
package mux_arb_pkg;

  localparam int NREQ  = 4;
  localparam int SEL_W = 2;

  typedef enum logic {
    IDLE  = 1'b0,
    GRANT = 1'b1
  } state_e;

  function automatic logic [NREQ-1:0] onehot(input logic [SEL_W-1:0] sel);
    logic [NREQ-1:0] v;
    v      = '0;
    v[sel] = 1'b1;
    return v;
  endfunction

endpackage

// File: rtl/mux_rr_arbiter_if.sv
// Requester-side bus of the round-robin mux arbiter.
// MUX_ARB_LOCK_EN adds the lock input that extends a tenure past MAX_HOLD.
interface mux_rr_arbiter_if;
  import mux_arb_pkg::*;

  // req[i] is a level request held by requester i until it is done with the mux;
  // gnt[i] (one-hot, registered) is the acknowledge, and a tenure ends on the edge
  // where req[i] is sampled low or the hold budget runs out.
  logic [NREQ-1:0] req;
  logic [NREQ-1:0] gnt;
  logic            S1;
  logic            S0;
  logic            busy;

`ifdef MUX_ARB_LOCK_EN
  logic            lock;

  modport master (output req, output lock, input gnt, input S1, input S0, input busy);
  modport slave  (input req, input lock, output gnt, output S1, output S0, output busy);
`else
  modport master (output req, input gnt, input S1, input S0, input busy);
  modport slave  (input req, output gnt, output S1, output S0, output busy);
`endif

endinterface

// File: rtl/mux_rr_arbiter_pick.sv
// Rotating-priority encoder: first requester at or after ptr, wrapping 3 -> 0.
module mux_arb_rr_pick
  import mux_arb_pkg::*;
(
  input  logic [NREQ-1:0]  req_i,
  input  logic [SEL_W-1:0] ptr_i,
  output logic             any_o,
  output logic [SEL_W-1:0] idx_o
);

  logic [SEL_W-1:0] cand;

  // Scan from the farthest position down so the nearest requester to ptr wins last.
  always_comb begin
    any_o = 1'b0;
    idx_o = '0;
    cand  = '0;
    for (int k = NREQ - 1; k >= 0; k--) begin
      cand = ptr_i + SEL_W'(k);
      if (req_i[cand]) begin
        any_o = 1'b1;
        idx_o = cand;
      end
    end
  end

endmodule

// File: rtl/mux_rr_arbiter.sv
// Round-robin arbiter driving the select pins of a 4:1 mux, tenure bounded by MAX_HOLD.
// Define MUX_ARB_LOCK_EN to add a lock input that suppresses tenure expiry.
module mux_rr_arbiter
  import mux_arb_pkg::*;
#(
  parameter int MAX_HOLD = 8,
  parameter int CNT_W    = 8
) (
  input  logic                clk,
  input  logic                rst_n,
  mux_rr_arbiter_if.slave     bus,
  output state_e              dbg_state_o,
  output logic [CNT_W-1:0]    dbg_hold_cnt_o,
  output logic [SEL_W-1:0]    dbg_ptr_o
);

  localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(MAX_HOLD - 1);

  state_e           state_q;
  logic [SEL_W-1:0] ptr_q;
  logic [SEL_W-1:0] sel_q;
  logic [CNT_W-1:0] hold_q;
  logic [NREQ-1:0]  gnt_q;

  logic [SEL_W-1:0] ptr_d;
  logic [SEL_W-1:0] pick_idx;
  logic             pick_any;
  logic             own_req;
  logic             at_last;
  logic             lock_hold;
  logic             keep;

`ifdef MUX_ARB_LOCK_EN
  assign lock_hold = bus.lock;
`else
  assign lock_hold = 1'b0;
`endif

  assign own_req = bus.req[sel_q];
  assign at_last = (hold_q == HOLD_LAST);
  assign keep    = (state_q == GRANT) && own_req && (!at_last || lock_hold);

  // On release the search starts just past the owner, so the owner is considered
  // last and only wins again when it is the sole requester.
  assign ptr_d = (state_q == GRANT) ? sel_q + SEL_W'(1) : ptr_q;

  mux_arb_rr_pick u_pick (
    .req_i (bus.req),
    .ptr_i (ptr_d),
    .any_o (pick_any),
    .idx_o (pick_idx)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      ptr_q   <= '0;
      sel_q   <= '0;
      hold_q  <= '0;
      gnt_q   <= '0;
    end else if (keep) begin
      if (!at_last) hold_q <= hold_q + CNT_W'(1);
    end else begin
      ptr_q  <= ptr_d;
      hold_q <= '0;
      if (pick_any) begin
        state_q <= GRANT;
        gnt_q   <= onehot(pick_idx);
        sel_q   <= pick_idx;
      end else begin
        // sel_q is left alone so the mux select does not move while idle
        state_q <= IDLE;
        gnt_q   <= '0;
      end
    end
  end

  assign bus.gnt  = gnt_q;
  assign bus.S1   = sel_q[1];
  assign bus.S0   = sel_q[0];
  assign bus.busy = |gnt_q;

  assign dbg_state_o    = state_q;
  assign dbg_hold_cnt_o = hold_q;
  assign dbg_ptr_o      = ptr_q;

endmodule

// File: tb/tb_mux_rr_arbiter.sv
// Bench for mux_rr_arbiter: two instances (MAX_HOLD=2 and MAX_HOLD=8), directed vectors.
module tb_mux_rr_arbiter;
  import mux_arb_pkg::*;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  mux_rr_arbiter_if bus2();
  mux_rr_arbiter_if bus8();

  state_e     st2, st8;
  logic [7:0] hold2, hold8;
  logic [1:0] ptr2, ptr8;

  mux_rr_arbiter #(.MAX_HOLD(2), .CNT_W(8)) u_dut2 (
    .clk(clk), .rst_n(rst_n), .bus(bus2),
    .dbg_state_o(st2), .dbg_hold_cnt_o(hold2), .dbg_ptr_o(ptr2)
  );

  mux_rr_arbiter #(.MAX_HOLD(8), .CNT_W(8)) u_dut8 (
    .clk(clk), .rst_n(rst_n), .bus(bus8),
    .dbg_state_o(st8), .dbg_hold_cnt_o(hold8), .dbg_ptr_o(ptr8)
  );

  // data sources behind the mux, and the mux itself
  logic [7:0] d_val [4] = '{8'h3C, 8'h5A, 8'hA5, 8'hC3};

  int n_chk  = 0;
  int n_pass = 0;

  // entry: {chk_hold, hold[7:0], busy, sel[1:0], gnt[3:0]}
  logic [15:0] exp2_q[$];
  logic [15:0] exp8_q[$];

  logic [3:0] rot_g [15] = '{4'h1, 4'h1, 4'h2, 4'h2, 4'h4, 4'h4, 4'h8, 4'h8,
                             4'h1, 4'h1, 4'h2, 4'h2, 4'h4, 4'h4, 4'h8};
  logic [1:0] rot_s [15] = '{2'd0, 2'd0, 2'd1, 2'd1, 2'd2, 2'd2, 2'd3, 2'd3,
                             2'd0, 2'd0, 2'd1, 2'd1, 2'd2, 2'd2, 2'd3};

  task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  function automatic logic [1:0] idx_of(input logic [3:0] g);
    logic [1:0] r;
    r = 2'd0;
    for (int i = 3; i >= 0; i--) if (g[i]) r = 2'(i);
    return r;
  endfunction

  // ---------------- driver tasks ----------------
  task automatic cyc2(input logic [3:0] r, input logic [3:0] g, input logic [1:0] s);
    bus2.req = r;
    @(posedge clk); #1;
    exp2_q.push_back({1'b0, 8'h00, |g, s, g});
  endtask

  task automatic cyc8(input logic [3:0] r, input logic [3:0] g, input logic [1:0] s,
                      input logic [7:0] h);
    bus8.req = r;
    @(posedge clk); #1;
    exp8_q.push_back({1'b1, h, |g, s, g});
  endtask

  // ---------------- scoreboard monitor ----------------
  task automatic compare_out(input string tag, input logic [15:0] e, input logic [3:0] g,
                             input logic [1:0] s, input logic b, input logic [7:0] h);
    logic [7:0] y;
    logic [7:0] dsel;
    check({tag, " gnt"},    16'(g), 16'(e[3:0]));
    check({tag, " sel"},    16'(s), 16'(e[5:4]));
    check({tag, " busy"},   16'(b), 16'(e[6]));
    check({tag, " onehot"}, 16'($onehot0(g)), 16'(1));
    if (e[15]) check({tag, " hold"}, 16'(h), 16'(e[14:7]));
    if (b) begin
      y    = d_val[s];
      dsel = d_val[idx_of(g)];
      check({tag, " y"}, 16'(y), 16'(dsel));
    end
  endtask

  always @(negedge clk) begin
    if (exp2_q.size() > 0)
      compare_out("d2", exp2_q.pop_front(), bus2.gnt, {bus2.S1, bus2.S0}, bus2.busy, hold2);
    if (exp8_q.size() > 0)
      compare_out("d8", exp8_q.pop_front(), bus8.gnt, {bus8.S1, bus8.S0}, bus8.busy, hold8);
  end

  task automatic check_reset(input string tag);
    check({tag, " gnt2"},  16'(bus2.gnt), 16'(0));
    check({tag, " sel2"},  16'({bus2.S1, bus2.S0}), 16'(0));
    check({tag, " busy2"}, 16'(bus2.busy), 16'(0));
    check({tag, " ptr2"},  16'(ptr2), 16'(0));
    check({tag, " st2"},   16'(st2), 16'(IDLE));
    check({tag, " gnt8"},  16'(bus8.gnt), 16'(0));
    check({tag, " hold8"}, 16'(hold8), 16'(0));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- stimulus ----------------
  initial begin
    rst_n    = 1'b0;
    bus2.req = 4'b0000;
    bus8.req = 4'b0000;
`ifdef MUX_ARB_LOCK_EN
    bus2.lock = 1'b0;
    bus8.lock = 1'b0;
`endif
    repeat (2) @(posedge clk);
    #1;
    check_reset("por");
    @(negedge clk);
    rst_n = 1'b1;

    // rotation with all requesting, two cycles per tenure
    for (int i = 0; i < 15; i++) cyc2(4'b1111, rot_g[i], rot_s[i]);
    // owner 3 releases with 0011 pending: pointer wraps to 0
    cyc2(4'b0011, 4'b0001, 2'd0);
    cyc2(4'b0011, 4'b0001, 2'd0);
    cyc2(4'b0011, 4'b0010, 2'd1);
    // idle keeps last select; pointer now 2, so 0011 goes to requester 0
    cyc2(4'b0000, 4'b0000, 2'd1);
    cyc2(4'b0000, 4'b0000, 2'd1);
    cyc2(4'b0011, 4'b0001, 2'd0);
    cyc2(4'b0011, 4'b0001, 2'd0);

    // reset mid-grant: outputs clear at once, pointer back to 0
    @(negedge clk); #1;
    rst_n = 1'b0;
    #1;
    check_reset("rst1");
    bus2.req = 4'b1111;
    @(negedge clk);
    rst_n = 1'b1;
    cyc2(4'b1111, 4'b0001, 2'd0);
    cyc2(4'b1111, 4'b0001, 2'd0);

    @(negedge clk); #1;
    rst_n = 1'b0;
    #1;
    check_reset("rst2");
    bus2.req = 4'b0100;
    @(negedge clk);
    rst_n = 1'b1;
    cyc2(4'b0100, 4'b0100, 2'd2);
    cyc2(4'b0000, 4'b0000, 2'd2);

    // early release: owner 1 for 3 cycles then 1000
    cyc8(4'b0010, 4'b0010, 2'd1, 8'd0);
    cyc8(4'b0010, 4'b0010, 2'd1, 8'd1);
    cyc8(4'b0010, 4'b0010, 2'd1, 8'd2);
    cyc8(4'b1000, 4'b1000, 2'd3, 8'd0);
    cyc8(4'b0000, 4'b0000, 2'd3, 8'd0);

    // sole requester: continuous grant, counter restarts every 8 cycles
    for (int k = 0; k < 20; k++) cyc8(4'b0010, 4'b0010, 2'd1, 8'(k % 8));
    cyc8(4'b0000, 4'b0000, 2'd1, 8'd0);

`ifdef MUX_ARB_LOCK_EN
    bus8.lock = 1'b1;
    for (int k = 0; k < 20; k++) cyc8(4'b0011, 4'b0001, 2'd0, (k < 7) ? 8'(k) : 8'd7);
    bus8.lock = 1'b0;
    cyc8(4'b0011, 4'b0010, 2'd1, 8'd0);
`else
    for (int k = 0; k < 8; k++) cyc8(4'b0011, 4'b0001, 2'd0, 8'(k));
    cyc8(4'b0011, 4'b0010, 2'd1, 8'd0);
`endif
    cyc8(4'b0000, 4'b0000, 2'd1, 8'd0);

    @(negedge clk); #1;
    check("drain", 16'(exp2_q.size() + exp8_q.size()), 16'(0));
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
